// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase sequencer.
package traffic_pkg;

  localparam int unsigned REM_W     = 7;
  localparam int unsigned LAMP_W    = 3;
  localparam int unsigned PED_MIN_S = 5;

  typedef enum logic [1:0] {
    MG = 2'd0,
    MY = 2'd1,
    SG = 2'd2,
    SY = 2'd3
  } state_e;

  localparam logic [LAMP_W-1:0] LAMP_MAIN_G = 3'd0;
  localparam logic [LAMP_W-1:0] LAMP_MAIN_R = 3'd1;
  localparam logic [LAMP_W-1:0] LAMP_SUB_G  = 3'd2;
  localparam logic [LAMP_W-1:0] LAMP_SUB_R  = 3'd3;
  localparam logic [LAMP_W-1:0] LAMP_BLANK  = 3'd5;
  localparam logic [LAMP_W-1:0] LAMP_UNLIT  = 3'd7;

  // Everything the display driver renders, registered as one word.
  typedef struct packed {
    logic [REM_W-1:0]  main_rest_time;
    logic [REM_W-1:0]  sub_rest_time;
    logic              dis;
    logic              non;
    logic [LAMP_W-1:0] n1;
    logic [LAMP_W-1:0] n2;
  } disp_t;

  // Phase order MG -> MY -> SG -> SY -> MG.
  function automatic state_e next_state(input state_e s);
    case (s)
      MG:      next_state = MY;
      MY:      next_state = SG;
      SG:      next_state = SY;
      default: next_state = MG;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Mode inputs and display outputs of the sequencer.
// Optional PED_REQ_EN adds the pedestrian request level ped_req.
interface traffic_light_ctrl_if;

  logic       mode_off;
  logic       mode_maint;
`ifdef PED_REQ_EN
  logic       ped_req;
`endif
  logic [6:0] main_rest_time;
  logic [6:0] sub_rest_time;
  logic       dis;
  logic       non;
  logic [2:0] n1;
  logic [2:0] n2;

  // Controller side: drives modes, receives display data.
  modport master (
`ifdef PED_REQ_EN
    output ped_req,
`endif
    output mode_off, mode_maint,
    input  main_rest_time, sub_rest_time, dis, non, n1, n2
  );

  // Sequencer side.
  modport slave (
`ifdef PED_REQ_EN
    input  ped_req,
`endif
    input  mode_off, mode_maint,
    output main_rest_time, sub_rest_time, dis, non, n1, n2
  );

endinterface

// File: rtl/tick_gen.sv
// Half-second prescaler and second phase bit; ticks are registered so each
// is high exactly while the counter sits at TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic half_tick_o,
  output logic sec_tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             half_d, sec_d;

  // Next counter/phase; clear restarts the second from its beginning.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      phase_d = half_tick_o ? ~phase_q : phase_q;
    end
    half_d = (cnt_d == CNT_MAX);
    sec_d  = half_d & phase_d;
  end

  // Prescaler state and registered tick strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      half_tick_o <= (CNT_MAX == '0);
      sec_tick_o  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      half_tick_o <= half_d;
      sec_tick_o  <= sec_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light phase sequencer: green/yellow cycle, countdowns,
// lamp indices and off/maintenance display modes.
// Optional PED_REQ_EN: pedestrian request shortens main green to 5 s once per MG.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned MAIN_GREEN_S = 30,
  parameter int unsigned SUB_GREEN_S  = 20,
  parameter int unsigned YELLOW_S     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  bus
);

  localparam logic [REM_W-1:0] MAIN_DUR = REM_W'(MAIN_GREEN_S);
  localparam logic [REM_W-1:0] SUB_DUR  = REM_W'(SUB_GREEN_S);
  localparam logic [REM_W-1:0] YEL_DUR  = REM_W'(YELLOW_S);
  localparam disp_t DISP_RST = '{
    main_rest_time: REM_W'(MAIN_GREEN_S + YELLOW_S),
    sub_rest_time:  REM_W'(MAIN_GREEN_S + YELLOW_S),
    dis:            1'b0,
    non:            1'b0,
    n1:             LAMP_MAIN_G,
    n2:             LAMP_SUB_R
  };

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             blink_q, blink_d;
  logic             ylw_q, ylw_d;
  logic             abn_q, abn_d;
  disp_t            disp_q, disp_d;
  logic             tick_clr;
  logic             half_tick;
  logic             sec_tick;
`ifdef PED_REQ_EN
  logic             ped_used_q, ped_used_d;
`endif

  function automatic logic [REM_W-1:0] dur(input state_e s);
    case (s)
      MG:      dur = MAIN_DUR;
      SG:      dur = SUB_DUR;
      default: dur = YEL_DUR;
    endcase
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (tick_clr),
    .half_tick_o (half_tick),
    .sec_tick_o  (sec_tick)
  );

  // State register, countdown, blink bits and registered display word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MG;
      rem_q      <= MAIN_DUR;
      blink_q    <= 1'b0;
      ylw_q      <= 1'b0;
      abn_q      <= 1'b0;
      disp_q     <= DISP_RST;
`ifdef PED_REQ_EN
      ped_used_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      blink_q    <= blink_d;
      ylw_q      <= ylw_d;
      abn_q      <= abn_d;
      disp_q     <= disp_d;
`ifdef PED_REQ_EN
      ped_used_q <= ped_used_d;
`endif
    end
  end

  // Next state: held in off/maint, restart at MG on return, else count down.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ylw_d    = ylw_q;
    blink_d  = half_tick ? ~blink_q : blink_q;
    abn_d    = bus.mode_off | bus.mode_maint;
    tick_clr = 1'b0;
`ifdef PED_REQ_EN
    ped_used_d = ped_used_q;
`endif
    if (abn_d) begin
      state_d = state_q;
    end else if (abn_q) begin
      state_d  = MG;
      rem_d    = MAIN_DUR;
      ylw_d    = 1'b0;
      tick_clr = 1'b1;
`ifdef PED_REQ_EN
      ped_used_d = 1'b0;
`endif
    end else begin
      if (half_tick && (state_q == MY || state_q == SY)) begin
        ylw_d = ~ylw_q;
      end
      if (sec_tick) begin
        if (rem_q == REM_W'(1)) begin
          state_d = next_state(state_q);
          rem_d   = dur(next_state(state_q));
          ylw_d   = 1'b0;
`ifdef PED_REQ_EN
          if (next_state(state_q) == MG) begin
            ped_used_d = 1'b0;
          end
`endif
        end else begin
          rem_d = rem_q - REM_W'(1);
        end
      end
`ifdef PED_REQ_EN
      // One-shot shortening of main green; overrides a same-cycle decrement.
      if (state_q == MG && bus.ped_req && !ped_used_q && rem_q > REM_W'(PED_MIN_S)) begin
        rem_d      = REM_W'(PED_MIN_S);
        ped_used_d = 1'b1;
      end
`endif
    end
  end

  // Display word from the next-state values so it lines up with the state.
  always_comb begin
    disp_d    = '0;
    disp_d.n1 = LAMP_BLANK;
    disp_d.n2 = LAMP_BLANK;
    if (bus.mode_off) begin
      disp_d.non = 1'b1;
    end else if (bus.mode_maint) begin
      disp_d.dis = 1'b1;
      if (blink_d) begin
        disp_d.n1 = LAMP_MAIN_R;
        disp_d.n2 = LAMP_SUB_R;
      end
    end else begin
      case (state_d)
        MG: begin
          disp_d.main_rest_time = rem_d + YEL_DUR;
          disp_d.sub_rest_time  = rem_d + YEL_DUR;
          disp_d.n1             = LAMP_MAIN_G;
          disp_d.n2             = LAMP_SUB_R;
        end
        MY: begin
          disp_d.main_rest_time = rem_d;
          disp_d.sub_rest_time  = rem_d;
          disp_d.n1             = ylw_d ? LAMP_UNLIT : LAMP_MAIN_G;
          disp_d.n2             = LAMP_SUB_R;
        end
        SG: begin
          disp_d.main_rest_time = rem_d + YEL_DUR;
          disp_d.sub_rest_time  = rem_d + YEL_DUR;
          disp_d.n1             = LAMP_MAIN_R;
          disp_d.n2             = LAMP_SUB_G;
        end
        default: begin
          disp_d.main_rest_time = rem_d;
          disp_d.sub_rest_time  = rem_d;
          disp_d.n1             = LAMP_MAIN_R;
          disp_d.n2             = ylw_d ? LAMP_UNLIT : LAMP_SUB_G;
        end
      endcase
    end
  end

  assign bus.main_rest_time = disp_q.main_rest_time;
  assign bus.sub_rest_time  = disp_q.sub_rest_time;
  assign bus.dis            = disp_q.dis;
  assign bus.non            = disp_q.non;
  assign bus.n1             = disp_q.n1;
  assign bus.n2             = disp_q.n2;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a timeline model predicts each cycle's display
// word into a queue, which the scenario tasks pop and compare after each edge.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int TD   = 4;
`ifdef PED_REQ_EN
  localparam int MG_S = 20;
`else
  localparam int MG_S = 3;
`endif
  localparam int SG_S = 2;
  localparam int Y_S  = 2;
  localparam int SEC  = 2 * TD;
  localparam int CYC  = (MG_S + SG_S + 2 * Y_S) * SEC;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl #(
    .TICK_DIV     (TD),
    .MAIN_GREEN_S (MG_S),
    .SUB_GREEN_S  (SG_S),
    .YELLOW_S     (Y_S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  disp_t sb_q[$];
  int    tcnt;
  bit    m_blink;
  bit    prev_abn;
  bit    used;

  function automatic disp_t observed();
    disp_t d;
    d.main_rest_time = bus.main_rest_time;
    d.sub_rest_time  = bus.sub_rest_time;
    d.dis            = bus.dis;
    d.non            = bus.non;
    d.n1             = bus.n1;
    d.n2             = bus.n2;
    return d;
  endfunction

  function automatic disp_t reset_word();
    disp_t d;
    d.main_rest_time = 7'(MG_S + Y_S);
    d.sub_rest_time  = 7'(MG_S + Y_S);
    d.dis = 1'b0;
    d.non = 1'b0;
    d.n1  = 3'd0;
    d.n2  = 3'd3;
    return d;
  endfunction

  // Display word at t clocks after the last MG restart, from the phase table.
  function automatic disp_t normal_exp(input int t);
    disp_t d;
    int pos, q, rem;
    pos = t % CYC;
    d   = '0;
    if (pos < MG_S * SEC) begin
      rem = MG_S - pos / SEC;
      d.main_rest_time = 7'(rem + Y_S);
      d.sub_rest_time  = 7'(rem + Y_S);
      d.n1 = 3'd0;
      d.n2 = 3'd3;
    end else if (pos < (MG_S + Y_S) * SEC) begin
      q   = pos - MG_S * SEC;
      rem = Y_S - q / SEC;
      d.main_rest_time = 7'(rem);
      d.sub_rest_time  = 7'(rem);
      d.n1 = ((q / TD) % 2 == 1) ? 3'd7 : 3'd0;
      d.n2 = 3'd3;
    end else if (pos < (MG_S + Y_S + SG_S) * SEC) begin
      q   = pos - (MG_S + Y_S) * SEC;
      rem = SG_S - q / SEC;
      d.main_rest_time = 7'(rem + Y_S);
      d.sub_rest_time  = 7'(rem + Y_S);
      d.n1 = 3'd1;
      d.n2 = 3'd2;
    end else begin
      q   = pos - (MG_S + Y_S + SG_S) * SEC;
      rem = Y_S - q / SEC;
      d.main_rest_time = 7'(rem);
      d.sub_rest_time  = 7'(rem);
      d.n1 = 3'd1;
      d.n2 = ((q / TD) % 2 == 1) ? 3'd7 : 3'd2;
    end
    return d;
  endfunction

  function automatic int mg_rem(input int t);
    int pos;
    pos = t % CYC;
    return (pos < MG_S * SEC) ? (MG_S - pos / SEC) : 0;
  endfunction

  task automatic model_reset();
    tcnt     = 0;
    m_blink  = 1'b0;
    prev_abn = 1'b0;
    used     = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of mode inputs, push the predicted word, step past the edge.
  task automatic drive_cycle(input bit off, input bit maint, input bit ped);
    disp_t e;
    bit    abn;
    int    r0, r1;
    bus.mode_off   = off;
    bus.mode_maint = maint;
`ifdef PED_REQ_EN
    bus.ped_req    = ped;
`endif
    abn = off | maint;
    if (tcnt % TD == TD - 1) m_blink = ~m_blink;
    if (prev_abn && !abn) begin
      tcnt = 0;
      used = 1'b0;
    end else begin
      r0   = mg_rem(tcnt);
      tcnt = tcnt + 1;
      if (!abn && ped && !used && r0 > 5) begin
        r1   = mg_rem(tcnt);
        tcnt = tcnt + (r1 - 5) * SEC;
        used = 1'b1;
      end
      if (!abn && tcnt % CYC == 0) used = 1'b0;
    end
    prev_abn = abn;
    if (off) begin
      e = '0; e.non = 1'b1; e.n1 = 3'd5; e.n2 = 3'd5;
    end else if (maint) begin
      e = '0; e.dis = 1'b1;
      e.n1 = m_blink ? 3'd1 : 3'd5;
      e.n2 = m_blink ? 3'd3 : 3'd5;
    end else begin
      e = normal_exp(tcnt);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    disp_t got, exp;
    bus.mode_off   = 1'b0;
    bus.mode_maint = 1'b0;
`ifdef PED_REQ_EN
    bus.ped_req    = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    got = observed();
    checks++;
    if (got !== reset_word()) begin
      errors++;
      $display("FAIL reset_value: got %h expected %h", got, reset_word());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * SEC; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_run t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
`ifndef PED_REQ_EN
    checks++;
    if (bus.main_rest_time !== 7'd2 || bus.n1 !== 3'd0) begin
      errors++;
      $display("FAIL my_entry: got time %0d n1 %0d expected time 2 n1 0",
               bus.main_rest_time, bus.n1);
    end
`endif
  endtask

  task automatic test_full_cycle();
    disp_t got, exp;
    for (int i = 0; i < CYC + SEC; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL full_cycle t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
  endtask

  task automatic test_off_mid_sg();
    disp_t got, exp;
    bit    found;
    int    lo;
    lo    = (MG_S + Y_S) * SEC + 3;
    found = 1'b0;
    for (int i = 0; i < CYC + 1; i++) begin
      if (tcnt % CYC == lo) begin
        found = 1'b1;
        break;
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL to_sg t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sg_sync: got no SG position expected pos %0d", lo);
    end
    for (int i = 0; i < 6 + 3 * SEC + 2; i++) begin
      drive_cycle(i < 6, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL off_mode step=%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_maint_priority();
    disp_t got, exp;
    for (int i = 0; i < 4 + 4 * TD + 1 + 2 * SEC; i++) begin
      drive_cycle(i < 4, i < 4 + 4 * TD + 1, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL maint_mode step=%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    disp_t got, exp;
    bit    found;
    int    tgt;
    tgt   = MG_S * SEC + 5;
    found = 1'b0;
    for (int i = 0; i < CYC + 1; i++) begin
      if (tcnt % CYC == tgt) begin
        found = 1'b1;
        break;
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL to_my t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL my_sync: got no MY position expected pos %0d", tgt);
    end
    #2 rst_n = 1'b0;
    #1;
    got = observed();
    checks++;
    if (got !== reset_word()) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", got, reset_word());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * SEC; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped_req();
    disp_t got, exp;
    bit    found;
    int    tgt;
    tgt   = 5 * SEC + 2;
    found = 1'b0;
    for (int i = 0; i < CYC + 1; i++) begin
      if (tcnt % CYC == tgt) begin
        found = 1'b1;
        break;
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL to_rem15 t=%0d: got %h expected %h", tcnt, got, exp);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rem15_sync: got no rem 15 position expected pos %0d", tgt);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front();
    got = observed();
    checks++;
    if (got !== exp || bus.main_rest_time !== 7'd7) begin
      errors++;
      $display("FAIL ped_shorten: got %h expected %h (time 7)", got, exp);
    end
    for (int i = 0; i < CYC; i++) begin
      drive_cycle(1'b0, 1'b0, i < 2 * SEC);
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ped_second step=%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_full_cycle();
    test_off_mid_sg();
    test_maint_priority();
    test_async_reset();
`ifdef PED_REQ_EN
    test_ped_req();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Phase sequencer for the two-road traffic-light project. It runs the main/sub green-yellow cycle and produces the countdown values, lamp indices and display-mode flags. These drive the seven-segment/lamp display driver directly. It owns the one-second timebase; the display driver only renders what this block reports.

Parameters:
TICK_DIV, 50_000_000, clk cycles per half second (the half-second tick drives yellow blink; two half-ticks make one second)
MAIN_GREEN_S, 30, main-road green duration in seconds (1..96)
SUB_GREEN_S, 20, sub-road green duration in seconds (1..96)
YELLOW_S, 3, yellow duration in seconds, each road (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode_off  in  1  level; all lamps and digits blank
mode_maint  in  1  level; digits show dashes, lamps flash
main_rest_time  out  7  seconds until the main road changes colour, 0..99
sub_rest_time  out  7  seconds until the sub road changes colour, 0..99
dis  out  1  display dashes
non  out  1  display blank
n1  out  3  main-road lamp index: 0 = main green, 1 = main red, 7 = unlit
n2  out  3  sub-road lamp index: 2 = sub green, 3 = sub red, 7 = unlit; n1 = n2 = 5 blanks every lamp

Behaviour:
- Mode priority: mode_off > mode_maint > normal. Modes are sampled every clk and take effect on the next edge.
- Prescaler: counts 0..TICK_DIV-1 and emits half_tick for one cycle at the wrap. A sec_tick phase bit toggles on each half_tick; sec_tick = half_tick AND phase == 1.
- Normal FSM states: MG, MY, SG, SY.
  - MG: duration MAIN_GREEN_S. n1 = 0, n2 = 3.
  - MY: duration YELLOW_S. n1 alternates 0/7 on each half_tick, starting at 0. n2 = 3.
  - SG: duration SUB_GREEN_S. n1 = 1, n2 = 2.
  - SY: duration YELLOW_S. n1 = 1. n2 alternates 2/7 on each half_tick, starting at 2.
- Countdown register rem (7 bits):
  - Loaded with the full state duration on entry.
  - Decremented on sec_tick.
  - On a sec_tick with rem == 1: move to the next state (MG→MY→SG→SY→MG) and load the new duration in the same cycle. rem never reads 0 in normal mode.
- Reported times:
  - In MG: main_rest_time = rem + YELLOW_S, sub_rest_time = rem + YELLOW_S.
  - In MY: both equal rem.
  - In SG/SY: the same mapping applies to the sub road.
  - All sums are ≤ 99 by the parameter limits. Outputs are registered.
- Off mode: non = 1, dis = 0, n1 = n2 = 5, both times 0. The FSM is held.
- Maint mode: dis = 1, non = 0, both times 0. n1 = 1 and n2 = 3 while blink = 1; n1 = n2 = 5 while blink = 0. Blink toggles on each half_tick.
- Leaving off or maint for normal:
  - FSM restarts at MG with rem = MAIN_GREEN_S.
  - Prescaler and phase are cleared in the same cycle.
- Reset values (asynchronous): state MG, rem = MAIN_GREEN_S, prescaler 0, phase 0, blink 0, n1 = 0, n2 = 3, dis = 0, non = 0, main_rest_time = sub_rest_time = MAIN_GREEN_S + YELLOW_S.
- Reset asserted mid-phase aborts immediately to the reset values above.

Optional Feature:
PED_REQ_EN
- Defined: adds input ped_req (1 bit, level). When ped_req is high in MG and rem > 5, rem is forced to 5 on the next clk. The request is then ignored until the next MG entry; a one-shot latch clears on entry to MG. The same 5-second limit must show on main_rest_time immediately.
- Undefined: no ped_req port and no shortening logic.

Decomposition:
- Package traffic_pkg:
  - state enum (MG, MY, SG, SY)
  - lamp index constants: LAMP_MAIN_G = 0, LAMP_MAIN_R = 1, LAMP_SUB_G = 2, LAMP_SUB_R = 3, LAMP_UNLIT = 7, LAMP_BLANK = 5
  - PED_MIN_S = 5
- One sub-module, tick_gen: prescaler plus phase bit, output half_tick and sec_tick, with a synchronous clear input used on the mode exit.

Test Plan:
- TICK_DIV = 4, MAIN_GREEN_S = 3, SUB_GREEN_S = 2, YELLOW_S = 2. Release reset → main_rest_time = 5, n1 = 0, n2 = 3. After 24 clk: state MY, main_rest_time = 2.
- Run one full cycle (MAIN_GREEN_S + SUB_GREEN_S + 2·YELLOW_S seconds = 72 clk) → back to MG with rem = 3. Check the n1 blink 0/7/0/7 during MY and the n2 2/7 blink during SY.
- Assert mode_off mid-SG → next cycle non = 1, n1 = n2 = 5, times 0. Deassert → MG, rem = 3, prescaler 0.
- Assert mode_maint and mode_off together → off wins. Drop mode_off → dis = 1, lamps toggle between (1, 3) and (5, 5) on each half_tick.
- Pull rst_n low mid-MY → outputs take the reset values asynchronously, before the next clk edge.
- With PED_REQ_EN and MAIN_GREEN_S = 20: assert ped_req at rem = 15 → rem = 5 next clk, main_rest_time = 7. A second ped_req in the same MG has no effect.
